regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised successor to the core's register file: configurable width and depth, hardwired zero register, optional write-to-read bypass, and a per-register pending-write scoreboard for the pipelined core. It sits between decode/issue (sources read, destinations marked busy) and writeback (results written, busy cleared). Hazard detection in the pipeline control reads its `busy1`/`busy2` outputs to stall issue.

## Interface
- `XLEN`, 64, data width in bits
- `NREGS`, 32, number of architectural registers (2..32)
- `ADDR_W`, 5, register index width; must satisfy 2^ADDR_W >= NREGS
- `ZERO_REG`, 1, 1 = register 0 reads as zero, never written, never busy
- `BYPASS`, 1, 1 = same-cycle writeback data forwarded to read ports

Ports:
- `clock`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately
- `rs1`  in  ADDR_W  read port 1 index
- `rs2`  in  ADDR_W  read port 2 index
- `readData1`  out  XLEN  read port 1 data
- `readData2`  out  XLEN  read port 2 data
- `busy1`  out  1  register `rs1` has a pending, uncompleted write
- `busy2`  out  1  register `rs2` has a pending, uncompleted write
- `rd`  in  ADDR_W  writeback destination index
- `writeData`  in  XLEN  writeback data
- `regWrite`  in  1  writeback strobe
- `issueValid`  in  1  instruction issued; mark `issueRd` busy
- `issueRd`  in  ADDR_W  destination of issued instruction
- `flush`  in  1  clear all busy bits (pipeline flush)
- `pendingCount`  out  ADDR_W+1  number of busy registers

## Operation
- Storage: NREGS x XLEN array plus NREGS busy bits plus `pendingCount` register.
- Reset (`reset`=0, asynchronous): all registers 0, all busy bits 0, `pendingCount`=0; reads return 0, `busy1`/`busy2`=0. Held while low.
- Write: on rising edge with `regWrite`=1, `rd` < NREGS, and not (`ZERO_REG` and `rd`=0): `reg[rd]` <= `writeData`. Out-of-range `rd` ignored.
- Read (combinational): `readDataN` = 0 if `rsN` >= NREGS or (`ZERO_REG` and `rsN`=0); else `writeData` if `BYPASS` and `regWrite` and `rd`=`rsN`; else `reg[rsN]`.
- Busy set: rising edge with `issueValid`=1, valid non-zero (per `ZERO_REG`) in-range `issueRd`, `flush`=0.
- Busy clear: rising edge with `regWrite`=1 on valid `rd`.
- Same-edge issue and writeback to same register: set wins (newer instruction pending); data still written.
- `flush`=1: all busy bits 0 next edge, overrides issue; data writes still performed.
- `busyN` = busy[`rsN`] AND NOT (`BYPASS` and `regWrite` and `rd`=`rsN`); 0 for zero/out-of-range index.
- `pendingCount` registered; equals popcount of busy bits at all times (updated same edge as bits: +1 on set of non-busy reg, -1 on clear, net 0 when both or re-issue of busy reg; 0 on flush). Never exceeds NREGS.

## Timing
- Read latency 0 cycles (combinational from `rsN`, `rd`, `regWrite`, `writeData`).
- Write latency 1 edge; with `BYPASS`=0 new value visible only after the edge.
- Busy set/clear visible the cycle after the edge; `pendingCount` likewise.
- No handshake back-pressure; every strobe is accepted on its edge.
- Reset asserted mid-operation: state clears asynchronously regardless of clock; first update on the first rising edge after `reset` returns to 1.

## Test plan
- Reset: write 20 to x1 and 15 to x5, drive `reset`=0 between edges -> `readData1`(rs1=1)=0 immediately, `pendingCount`=0.
- Write/read/zero: write 0xDEAD to x5, then write 7 to x0 -> rs1=5 gives 0xDEAD next cycle; rs2=0 gives 0; out-of-range index (NREGS=24, rs=30) gives 0.
- Bypass: `regWrite`=1, rd=6, writeData=42, rs1=6 same cycle -> `readData1`=42 before edge with `BYPASS`=1; old value with `BYPASS`=0.
- Scoreboard: issue x3, x4 on consecutive edges -> `pendingCount`=2, `busy1`(rs1=3)=1; writeback x3 -> `busy1` drops in writeback cycle (bypass), `pendingCount`=1 after edge.
- Simultaneous: issue x7 and writeback x7 same edge -> x7 data updated, busy[7]=1, count unchanged net +1 only if x7 previously idle; re-issue busy x7 -> count unchanged.
- Flush: 5 registers busy, `flush`=1 with `issueValid`=1 for x9 -> all busy 0, `pendingCount`=0, x9 not busy.

Source files
------------

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Parametrised register file with a hardwired zero register,
//               optional write-to-read bypass and a pending-write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int XLEN     = 64,
    parameter int NREGS    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic [XLEN-1:0]   readData1,
    output logic [XLEN-1:0]   readData2,
    output logic              busy1,
    output logic              busy2,
    input  logic [ADDR_W-1:0] rd,
    input  logic [XLEN-1:0]   writeData,
    input  logic              regWrite,
    input  logic              issueValid,
    input  logic [ADDR_W-1:0] issueRd,
    input  logic              flush,
    output logic [ADDR_W:0]   pendingCount
);

    localparam logic [ADDR_W:0] c_NREGS = (ADDR_W+1)'(NREGS);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [ADDR_W:0]  r_count;

    logic             w_rs1_ok, w_rs2_ok, w_wr_ok, w_iss_ok;
    logic             w_byp1, w_byp2;
    logic [NREGS-1:0] w_busy_next;
    logic [ADDR_W:0]  w_count_next;

    // An index is usable when it is in range and is not the hardwired zero register.
    assign w_rs1_ok = ({1'b0, rs1} < c_NREGS) && !((ZERO_REG != 0) && (rs1 == '0));
    assign w_rs2_ok = ({1'b0, rs2} < c_NREGS) && !((ZERO_REG != 0) && (rs2 == '0));
    assign w_wr_ok  = regWrite && ({1'b0, rd} < c_NREGS) && !((ZERO_REG != 0) && (rd == '0));
    assign w_iss_ok = issueValid && ({1'b0, issueRd} < c_NREGS)
                      && !((ZERO_REG != 0) && (issueRd == '0));

    assign w_byp1 = (BYPASS != 0) && regWrite && (rd == rs1);
    assign w_byp2 = (BYPASS != 0) && regWrite && (rd == rs2);

    assign readData1 = !w_rs1_ok ? '0 : (w_byp1 ? writeData : r_regs[rs1]);
    assign readData2 = !w_rs2_ok ? '0 : (w_byp2 ? writeData : r_regs[rs2]);

    assign busy1 = w_rs1_ok && r_busy[rs1] && !w_byp1;
    assign busy2 = w_rs2_ok && r_busy[rs2] && !w_byp2;

    assign pendingCount = r_count;

    // Clear is applied before set so a same-edge re-issue keeps the register pending.
    always_comb begin
        w_busy_next = r_busy;
        if (flush) begin
            w_busy_next = '0;
        end else begin
            if (w_wr_ok)  w_busy_next[rd]      = 1'b0;
            if (w_iss_ok) w_busy_next[issueRd] = 1'b1;
        end
    end

    always_comb begin
        w_count_next = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_count_next = w_count_next + (ADDR_W+1)'(w_busy_next[i]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_ok) r_regs[rd] <= writeData;
            r_busy  <= w_busy_next;
            r_count <= w_count_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_scoreboard
// Description : Directed self-checking bench; instance a uses defaults,
//               instance b uses NREGS=24 without bypass, both on shared inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  rs1, rs2, rd, issueRd;
    logic [63:0] writeData;
    logic        regWrite, issueValid, flush;

    logic [63:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic        a_b1, a_b2, b_b1, b_b2;
    logic [5:0]  a_cnt, b_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    regfile_scoreboard u_a (
        .clock(clock), .reset(reset), .rs1(rs1), .rs2(rs2),
        .readData1(a_rd1), .readData2(a_rd2), .busy1(a_b1), .busy2(a_b2),
        .rd(rd), .writeData(writeData), .regWrite(regWrite),
        .issueValid(issueValid), .issueRd(issueRd), .flush(flush),
        .pendingCount(a_cnt)
    );

    regfile_scoreboard #(.NREGS(24), .BYPASS(0)) u_b (
        .clock(clock), .reset(reset), .rs1(rs1), .rs2(rs2),
        .readData1(b_rd1), .readData2(b_rd2), .busy1(b_b1), .busy2(b_b2),
        .rd(rd), .writeData(writeData), .regWrite(regWrite),
        .issueValid(issueValid), .issueRd(issueRd), .flush(flush),
        .pendingCount(b_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        regWrite = 1'b0; issueValid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        reset = 1'b0; rs1 = '0; rs2 = '0; rd = '0; issueRd = '0;
        writeData = '0; idle();
        tick(); tick();
        reset = 1'b1;
        rs1 = 5'd1;
        #1;
        chk("reset_rd1", a_rd1, 64'd0);
        chk("reset_cnt", {58'd0, a_cnt}, 64'd0);
        chk("reset_busy1", {63'd0, a_b1}, 64'd0);

        // write x1=20, then x5=15 while issuing x2
        regWrite = 1'b1; rd = 5'd1; writeData = 64'd20;
        tick();
        rd = 5'd5; writeData = 64'd15; issueValid = 1'b1; issueRd = 5'd2;
        tick();
        idle();
        rs1 = 5'd1; rs2 = 5'd5;
        #1;
        chk("pre_reset_x1", a_rd1, 64'd20);
        chk("pre_reset_x5", a_rd2, 64'd15);
        chk("pre_reset_cnt", {58'd0, a_cnt}, 64'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("async_reset_x1_a", a_rd1, 64'd0);
        chk("async_reset_x1_b", b_rd1, 64'd0);
        chk("async_reset_x5", a_rd2, 64'd0);
        chk("async_reset_cnt_a", {58'd0, a_cnt}, 64'd0);
        chk("async_reset_cnt_b", {58'd0, b_cnt}, 64'd0);
        tick();
        reset = 1'b1;

        // write/read/zero register/out-of-range
        regWrite = 1'b1; rd = 5'd5; writeData = 64'hDEAD;
        tick();
        rd = 5'd0; writeData = 64'd7;
        tick();
        rd = 5'd30; writeData = 64'h1234;
        tick();
        idle();
        rs1 = 5'd5; rs2 = 5'd0;
        #1;
        chk("x5_dead", a_rd1, 64'hDEAD);
        chk("x0_zero", a_rd2, 64'd0);
        rs1 = 5'd30;
        #1;
        chk("x30_in_range_a", a_rd1, 64'h1234);
        chk("x30_out_of_range_b", b_rd1, 64'd0);

        // bypass
        regWrite = 1'b1; rd = 5'd6; writeData = 64'h11;
        tick();
        writeData = 64'd42; rs1 = 5'd6;
        #1;
        chk("bypass_on_a", a_rd1, 64'd42);
        chk("bypass_off_b", b_rd1, 64'h11);
        tick();
        idle();
        #1;
        chk("after_write_b", b_rd1, 64'd42);

        // scoreboard issue/writeback
        issueValid = 1'b1; issueRd = 5'd3;
        tick();
        issueRd = 5'd4;
        tick();
        idle();
        rs1 = 5'd3; rs2 = 5'd4;
        #1;
        chk("cnt_two", {58'd0, a_cnt}, 64'd2);
        chk("busy_x3", {63'd0, a_b1}, 64'd1);
        regWrite = 1'b1; rd = 5'd3; writeData = 64'd5;
        #1;
        chk("busy_x3_bypassed_a", {63'd0, a_b1}, 64'd0);
        chk("busy_x3_nobypass_b", {63'd0, b_b1}, 64'd1);
        tick();
        idle();
        #1;
        chk("cnt_one", {58'd0, a_cnt}, 64'd1);
        chk("busy_x3_cleared", {63'd0, a_b1}, 64'd0);
        chk("busy_x4_held", {63'd0, a_b2}, 64'd1);

        // same-edge issue and writeback on idle x7
        issueValid = 1'b1; issueRd = 5'd7; regWrite = 1'b1; rd = 5'd7; writeData = 64'h77;
        tick();
        idle();
        rs1 = 5'd7;
        #1;
        chk("x7_data", a_rd1, 64'h77);
        chk("x7_busy", {63'd0, a_b1}, 64'd1);
        chk("cnt_after_x7", {58'd0, a_cnt}, 64'd2);
        issueValid = 1'b1;
        tick();
        issueRd = 5'd0;
        tick();
        idle();
        rs1 = 5'd0;
        #1;
        chk("cnt_reissue_and_x0", {58'd0, a_cnt}, 64'd2);
        chk("x0_never_busy", {63'd0, a_b1}, 64'd0);

        // flush overrides issue, data write still lands
        issueValid = 1'b1;
        issueRd = 5'd10; tick();
        issueRd = 5'd11; tick();
        issueRd = 5'd12; tick();
        idle();
        #1;
        chk("cnt_five", {58'd0, a_cnt}, 64'd5);
        flush = 1'b1; issueValid = 1'b1; issueRd = 5'd9;
        regWrite = 1'b1; rd = 5'd10; writeData = 64'hAB;
        tick();
        idle();
        rs1 = 5'd9; rs2 = 5'd10;
        #1;
        chk("flush_cnt_a", {58'd0, a_cnt}, 64'd0);
        chk("flush_cnt_b", {58'd0, b_cnt}, 64'd0);
        chk("flush_x9_idle", {63'd0, a_b1}, 64'd0);
        chk("flush_x10_idle", {63'd0, a_b2}, 64'd0);
        chk("flush_x10_data", a_rd2, 64'hAB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
